// File: rtl/vga_tile_fetch.sv
// Display-side text buffer reader: maps pixel counters to buffer word addresses,
// then selects the character lane from the returned word. Syncs stay aligned through the pipe.
module vga_tile_fetch #(
    parameter int unsigned H_RES          = 640,
    parameter int unsigned V_RES          = 480,
    parameter int unsigned TILE_W         = 8,
    parameter int unsigned TILE_H         = 16,
    parameter int unsigned CHARS_PER_WORD = 4,
    parameter int unsigned SINGLE_DATA    = 7,
    parameter int unsigned DATA_WIDTH     = 28,
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned CNT_WIDTH      = 10,
    parameter logic        SYNC_IDLE      = 1'b1
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic [CNT_WIDTH-1:0]          hcount_i,
    input  logic [CNT_WIDTH-1:0]          vcount_i,
    input  logic                          active_i,
    input  logic                          hsync_i,
    input  logic                          vsync_i,
    output logic [ADDR_WIDTH-1:0]         vr_addr_o,
    input  logic [DATA_WIDTH-1:0]         buf_data_i,
    output logic [SINGLE_DATA-1:0]        char_o,
    output logic [$clog2(TILE_H)-1:0]     glyph_row_o,
    output logic [$clog2(TILE_W)-1:0]     glyph_col_o,
    output logic                          active_o,
    output logic                          hsync_o,
    output logic                          vsync_o
);

    localparam int unsigned ROW_W         = $clog2(TILE_H);
    localparam int unsigned COL_W         = $clog2(TILE_W);
    localparam int unsigned LANE_W        = (CHARS_PER_WORD > 1) ? $clog2(CHARS_PER_WORD) : 1;
    localparam int unsigned LANE_SH       = (CHARS_PER_WORD > 1) ? $clog2(CHARS_PER_WORD) : 0;
    localparam int unsigned WORDS_PER_ROW = H_RES / TILE_W / CHARS_PER_WORD;
    localparam logic [CNT_WIDTH-1:0] H_LIM = CNT_WIDTH'(H_RES);
    localparam logic [CNT_WIDTH-1:0] V_LIM = CNT_WIDTH'(V_RES);

    logic [CNT_WIDTH-1:0]  tile_row;
    logic [CNT_WIDTH-1:0]  tile_col;
    logic [CNT_WIDTH-1:0]  word_col;
    logic [ADDR_WIDTH-1:0] row_scaled;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [LANE_W-1:0]     lane_in;
    logic                  in_view;

    always_comb begin
        tile_row = vcount_i >> ROW_W;
        tile_col = hcount_i >> COL_W;
        word_col = tile_col >> LANE_SH;
        lane_in  = LANE_W'(tile_col);
        in_view  = active_i && (hcount_i < H_LIM) && (vcount_i < V_LIM);
    end

    // Row stride is a constant, so the multiply collapses to a sum of shifted copies
    always_comb begin
        row_scaled = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (WORDS_PER_ROW[i]) begin
                row_scaled = row_scaled + (ADDR_WIDTH'(tile_row) << i);
            end
        end
        addr_next = row_scaled + ADDR_WIDTH'(word_col);
    end

    logic [LANE_W-1:0] s1_lane, s2_lane;
    logic [ROW_W-1:0]  s1_row,  s2_row;
    logic [COL_W-1:0]  s1_col,  s2_col;
    logic              s1_vld,  s2_vld;
    logic              s1_hs,   s2_hs;
    logic              s1_vs,   s2_vs;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            vr_addr_o <= '0;
            s1_lane   <= '0;
            s1_row    <= '0;
            s1_col    <= '0;
            s1_vld    <= 1'b0;
            s1_hs     <= SYNC_IDLE;
            s1_vs     <= SYNC_IDLE;
        end else begin
            // Address holds through blanking so the buffer sees no sweep
            if (in_view) begin
                vr_addr_o <= addr_next;
            end
            s1_lane <= lane_in;
            s1_row  <= ROW_W'(vcount_i);
            s1_col  <= COL_W'(hcount_i);
            s1_vld  <= in_view;
            s1_hs   <= hsync_i;
            s1_vs   <= vsync_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s2_lane <= '0;
            s2_row  <= '0;
            s2_col  <= '0;
            s2_vld  <= 1'b0;
            s2_hs   <= SYNC_IDLE;
            s2_vs   <= SYNC_IDLE;
        end else begin
            s2_lane <= s1_lane;
            s2_row  <= s1_row;
            s2_col  <= s1_col;
            s2_vld  <= s1_vld;
            s2_hs   <= s1_hs;
            s2_vs   <= s1_vs;
        end
    end

    logic [SINGLE_DATA-1:0] char_sel;

    always_comb begin
        char_sel = '0;
        for (int unsigned i = 0; i < CHARS_PER_WORD; i++) begin
            if (s2_lane == LANE_W'(i)) begin
                char_sel = buf_data_i[i*SINGLE_DATA +: SINGLE_DATA];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            char_o      <= '0;
            glyph_row_o <= '0;
            glyph_col_o <= '0;
            active_o    <= 1'b0;
            hsync_o     <= SYNC_IDLE;
            vsync_o     <= SYNC_IDLE;
        end else begin
            char_o      <= s2_vld ? char_sel : '0;
            glyph_row_o <= s2_row;
            glyph_col_o <= s2_col;
            active_o    <= s2_vld;
            hsync_o     <= s2_hs;
            vsync_o     <= s2_vs;
        end
    end

endmodule

// File: tb/tb_vga_tile_fetch.sv
// Bench for vga_tile_fetch: behavioural buffer with 1-cycle read, scoreboard
// of expected outputs 3 edges after each input, plus a vector table.
module tb_vga_tile_fetch;

    logic        clk_i;
    logic        rstn_i;
    logic [9:0]  hcount_i;
    logic [9:0]  vcount_i;
    logic        active_i;
    logic        hsync_i;
    logic        vsync_i;
    logic [9:0]  vr_addr_o;
    logic [27:0] buf_data_i;
    logic [6:0]  char_o;
    logic [3:0]  glyph_row_o;
    logic [2:0]  glyph_col_o;
    logic        active_o;
    logic        hsync_o;
    logic        vsync_o;

    vga_tile_fetch #(
        .H_RES(640), .V_RES(480), .TILE_W(8), .TILE_H(16),
        .CHARS_PER_WORD(4), .SINGLE_DATA(7), .DATA_WIDTH(28),
        .ADDR_WIDTH(10), .CNT_WIDTH(10), .SYNC_IDLE(1'b1)
    ) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .hcount_i(hcount_i), .vcount_i(vcount_i), .active_i(active_i),
        .hsync_i(hsync_i), .vsync_i(vsync_i),
        .vr_addr_o(vr_addr_o), .buf_data_i(buf_data_i),
        .char_o(char_o), .glyph_row_o(glyph_row_o), .glyph_col_o(glyph_col_o),
        .active_o(active_o), .hsync_o(hsync_o), .vsync_o(vsync_o)
    );

    initial clk_i = 1'b0;
    always #20 clk_i = ~clk_i;

    logic [27:0] mem [0:1023];
    always @(posedge clk_i) buf_data_i <= mem[vr_addr_o];

    typedef struct {
        logic [6:0] ch;
        logic [3:0] row;
        logic [2:0] col;
        logic       act;
        logic       hs;
        logic       vs;
    } exp_t;

    typedef struct {
        int         hc;
        int         vc;
        logic       act;
        logic       hs;
        logic       vs;
        logic [9:0] eaddr;
        exp_t       e;
    } vec_t;

    exp_t       sbq[$];
    int         checks = 0;
    int         errors = 0;
    logic [9:0] model_addr = '0;

    function automatic logic [6:0] model_char(int hc, int vc);
        int          w;
        int          l;
        logic [27:0] d;
        w = (vc / 16) * 20 + hc / 32;
        l = (hc / 8) % 4;
        d = mem[w];
        return d[l*7 +: 7];
    endfunction

    task automatic step(input int hc, input int vc, input logic act, input logic hs,
                        input logic vs, input logic [9:0] eaddr, input exp_t e);
        exp_t x;
        hcount_i = 10'(hc);
        vcount_i = 10'(vc);
        active_i = act;
        hsync_i  = hs;
        vsync_i  = vs;
        sbq.push_back(e);
        @(posedge clk_i);
        #1;
        checks++;
        if (vr_addr_o !== eaddr) begin
            errors++;
            $display("FAIL addr hc=%0d vc=%0d got %0d want %0d", hc, vc, vr_addr_o, eaddr);
        end
        if (sbq.size() == 3) begin
            x = sbq.pop_front();
            checks++;
            if (char_o !== x.ch || glyph_row_o !== x.row || glyph_col_o !== x.col ||
                active_o !== x.act || hsync_o !== x.hs || vsync_o !== x.vs) begin
                errors++;
                $display("FAIL pipe_out got ch=%h row=%0d col=%0d act=%b hs=%b vs=%b want ch=%h row=%0d col=%0d act=%b hs=%b vs=%b",
                         char_o, glyph_row_o, glyph_col_o, active_o, hsync_o, vsync_o,
                         x.ch, x.row, x.col, x.act, x.hs, x.vs);
            end
        end
    endtask

    task automatic drive_model(input int hc, input int vc, input logic act,
                               input logic hs, input logic vs);
        exp_t e;
        logic vis;
        vis = act && (hc < 640) && (vc < 480);
        if (vis) model_addr = 10'((vc / 16) * 20 + hc / 32);
        e.ch  = vis ? model_char(hc, vc) : 7'h00;
        e.row = 4'(vc % 16);
        e.col = 3'(hc % 8);
        e.act = vis;
        e.hs  = hs;
        e.vs  = vs;
        step(hc, vc, act, hs, vs, model_addr, e);
    endtask

    task automatic check_reset_vals(input string tag);
        checks++;
        if (vr_addr_o !== 10'd0 || char_o !== 7'd0 || glyph_row_o !== 4'd0 ||
            glyph_col_o !== 3'd0 || active_o !== 1'b0 || hsync_o !== 1'b1 || vsync_o !== 1'b1) begin
            errors++;
            $display("FAIL %s got addr=%0d ch=%h row=%0d col=%0d act=%b hs=%b vs=%b want all 0 syncs 1",
                     tag, vr_addr_o, char_o, glyph_row_o, glyph_col_o, active_o, hsync_o, vsync_o);
        end
    endtask

    vec_t       vt [7];
    logic [6:0] w0 [4];
    logic [27:0] t;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 28'($urandom);
        mem[0] = {7'h44, 7'h33, 7'h22, 7'h11};
        t = mem[599];
        mem[599] = {7'h7F, t[20:0]};
        w0 = '{7'h11, 7'h22, 7'h33, 7'h44};

        t = mem[1];
        vt[0] = '{40,  0,   1'b1, 1'b1, 1'b1, 10'd1,   '{t[13:7], 4'd0,  3'd0, 1'b1, 1'b1, 1'b1}};
        t = mem[20];
        vt[1] = '{0,   16,  1'b1, 1'b1, 1'b0, 10'd20,  '{t[6:0],  4'd0,  3'd0, 1'b1, 1'b1, 1'b0}};
        vt[2] = '{0,   31,  1'b1, 1'b0, 1'b1, 10'd20,  '{t[6:0],  4'd15, 3'd0, 1'b1, 1'b0, 1'b1}};
        vt[3] = '{639, 479, 1'b1, 1'b1, 1'b1, 10'd599, '{7'h7F,   4'd15, 3'd7, 1'b1, 1'b1, 1'b1}};
        vt[4] = '{700, 0,   1'b0, 1'b0, 1'b1, 10'd599, '{7'h00,   4'd0,  3'd4, 1'b0, 1'b0, 1'b1}};
        vt[5] = '{100, 500, 1'b1, 1'b1, 1'b0, 10'd599, '{7'h00,   4'd4,  3'd4, 1'b0, 1'b1, 1'b0}};
        vt[6] = '{8,   0,   1'b1, 1'b1, 1'b1, 10'd0,   '{7'h22,   4'd0,  3'd0, 1'b1, 1'b1, 1'b1}};

        rstn_i = 1'b0; hcount_i = '0; vcount_i = '0; active_i = 1'b0;
        hsync_i = 1'b1; vsync_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        check_reset_vals("reset_state");
        rstn_i = 1'b1;

        // First word: four lanes, eight pixels each
        for (int h = 0; h < 32; h++) begin
            exp_t e;
            e = '{w0[h / 8], 4'd0, 3'(h % 8), 1'b1, 1'b1, 1'b1};
            step(h, 0, 1'b1, 1'b1, 1'b1, 10'd0, e);
        end

        for (int i = 0; i < 7; i++) begin
            step(vt[i].hc, vt[i].vc, vt[i].act, vt[i].hs, vt[i].vs, vt[i].eaddr, vt[i].e);
        end
        model_addr = 10'd0;

        // hsync low for 96 cycles mid-line
        for (int h = 0; h < 120; h++) begin
            drive_model(h, 32, 1'b1, !(h >= 10 && h < 106), 1'b1);
        end

        // Reset mid-line while char 0x22 is on the output
        for (int h = 8; h < 16; h++) drive_model(h, 0, 1'b1, 1'b1, 1'b1);
        checks++;
        if (char_o !== 7'h22) begin
            errors++;
            $display("FAIL pre_reset_char got %h want 22", char_o);
        end
        #1 rstn_i = 1'b0;
        #1;
        check_reset_vals("async_reset");
        sbq.delete();
        model_addr = 10'd0;
        #5 rstn_i = 1'b1;
        repeat (3) drive_model(8, 0, 1'b1, 1'b1, 1'b1);
        checks++;
        if (char_o !== 7'h22 || active_o !== 1'b1) begin
            errors++;
            $display("FAIL recover_char got ch=%h act=%b want ch=22 act=1", char_o, active_o);
        end

        repeat (3) drive_model(0, 0, 1'b0, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
